add_sub_serial: RTL

ADD_SUB_SERIAL -- requirements
Module: add_sub_serial

---
 rtl/add_sub_serial.sv | 132 +++++++++++++
 1 files changed

// File: rtl/add_sub_serial.sv
// Bit-serial adder/subtractor: one full-adder cell, LSB first, WIDTH cycles per operation.
// Optional signed-overflow output ovf_out is compiled in with macro ADD_SUB_OVF_EN.
module add_sub_serial #(
  parameter int WIDTH = 8
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             start_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             opcode,
  output logic [WIDTH-1:0] sum_out,
  output logic             flag_out,
  output logic             busy_out,
  output logic             done_out
`ifdef ADD_SUB_OVF_EN
  ,
  output logic             ovf_out
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             op_q, op_d;
  logic             flag_q, flag_d;
`ifdef ADD_SUB_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic bit_b, bit_s, bit_c, last_bit;

  // B is inverted on its way into the cell when subtracting; carry was preloaded with 1.
  assign bit_b    = b_q[0] ^ op_q;
  assign bit_s    = a_q[0] ^ bit_b ^ carry_q;
  assign bit_c    = (a_q[0] & bit_b) | (carry_q & (a_q[0] ^ bit_b));
  assign last_bit = (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    op_d    = op_q;
    flag_d  = flag_q;
`ifdef ADD_SUB_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (start_in) begin
          state_d = RUN;
          cnt_d   = '0;
          a_d     = a_in;
          b_d     = b_in;
          op_d    = opcode;
          carry_d = opcode;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        res_d   = {bit_s, res_q[WIDTH-1:1]};
        carry_d = bit_c;
        if (last_bit) begin
          state_d = DONE;
          sum_d   = {bit_s, res_q[WIDTH-1:1]};
          flag_d  = bit_c ^ op_q;
`ifdef ADD_SUB_OVF_EN
          // carry_q here is the carry into the MSB, bit_c the carry out of it
          ovf_d   = bit_c ^ carry_q;
`endif
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      op_q    <= 1'b0;
      flag_q  <= 1'b0;
`ifdef ADD_SUB_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      op_q    <= op_d;
      flag_q  <= flag_d;
`ifdef ADD_SUB_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign sum_out  = sum_q;
  assign flag_out = flag_q;
  assign busy_out = (state_q == RUN);
  assign done_out = (state_q == DONE);
`ifdef ADD_SUB_OVF_EN
  assign ovf_out  = ovf_q;
`endif

endmodule
